hazard_scoreboard: RTL and testbench

Register-dependency scoreboard and issue controller for the decode stage of the 5-stage 32-bit RISC pipeline. It keeps one busy bit per architectural register, gates issue of the instruction held in decode until its source and destination registers are free, and releases registers on write-back. Issue control into the register-file read stage is driven by this block.

---
 rtl/hazard_scoreboard.sv | 99 +++++++++
 tb/tb_hazard_scoreboard.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Decode-stage register scoreboard: one busy bit per architectural register.
// Issue is held while a source or destination register is busy; write-back releases it.
module hazard_scoreboard #(
   parameter int unsigned NUM_REGS    = 32,
   parameter int unsigned ADDR_W      = 5,
   parameter int unsigned STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [31:0]            instr,
   input  logic                   instr_valid,
   input  logic                   rs1_used,
   input  logic                   rs2_used,
   input  logic                   rd_write,
   output logic                   issue_ready,
   output logic                   issue,
   input  logic                   wb_en,
   input  logic [ADDR_W-1:0]      wb_rd,
   output logic [NUM_REGS-1:0]    busy_vec,
   output logic [ADDR_W:0]        inflight,
   output logic [STALL_CNT_W-1:0] stall_count,
   output logic                   wb_err
);

   localparam int unsigned CntW = ADDR_W + 1;

   logic [ADDR_W-1:0]      rs1, rs2, rd;
   logic                   raw1, raw2, waw;
   logic                   set_en, clr_req, clr_en, same_reg;
   logic [NUM_REGS-1:0]    busy_q, busy_d;
   logic [CntW-1:0]        inflight_q, inflight_d;
   logic [STALL_CNT_W-1:0] stall_q, stall_d;
   logic                   err_q, err_d;
   logic                   unused_instr;

   assign rs1 = instr[15 +: ADDR_W];
   assign rs2 = instr[20 +: ADDR_W];
   assign rd  = instr[7 +: ADDR_W];
   assign unused_instr = ^{instr[31:25], instr[14:12], instr[6:0]};

   // Hazards look only at registered busy bits; no write-back bypass.
   assign raw1 = rs1_used && (rs1 != '0) && busy_q[rs1];
   assign raw2 = rs2_used && (rs2 != '0) && busy_q[rs2];
   assign waw  = rd_write && (rd != '0) && busy_q[rd];

   assign issue_ready = !(raw1 || raw2 || waw);
   assign issue       = instr_valid && issue_ready;

   assign set_en   = issue && rd_write && (rd != '0);
   assign clr_req  = wb_en && (wb_rd != '0);
   assign same_reg = set_en && (wb_rd == rd);
   assign clr_en   = clr_req && !same_reg && busy_q[wb_rd];

   always_comb begin
      busy_d = busy_q;
      if (set_en) busy_d[rd] = 1'b1;
      if (clr_en) busy_d[wb_rd] = 1'b0;
      busy_d[0] = 1'b0;
   end

   always_comb begin
      inflight_d = inflight_q;
      case ({set_en, clr_en})
         2'b10:   inflight_d = inflight_q + CntW'(1);
         2'b01:   inflight_d = inflight_q - CntW'(1);
         default: inflight_d = inflight_q;
      endcase
   end

   always_comb begin
      stall_d = stall_q;
      if (instr_valid && !issue_ready && (stall_q != '1)) begin
         stall_d = stall_q + STALL_CNT_W'(1);
      end
   end

   // A set on the same register in the same cycle is not an error.
   assign err_d = clr_req && !same_reg && !busy_q[wb_rd];

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q     <= '0;
         inflight_q <= '0;
         stall_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         busy_q     <= busy_d;
         inflight_q <= inflight_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
      end
   end

   assign busy_vec    = busy_q;
   assign inflight    = inflight_q;
   assign stall_count = stall_q;
   assign wb_err      = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table plus hand sequences,
// with a behavioural busy-bit model feeding a queue of expected registered outputs.
module tb_hazard_scoreboard;

   logic        clk;
   logic        reset;
   logic [31:0] instr;
   logic        instr_valid, rs1_used, rs2_used, rd_write, wb_en;
   logic [4:0]  wb_rd;
   logic        issue_ready, issue, wb_err;
   logic [31:0] busy_vec;
   logic [5:0]  inflight;
   logic [15:0] stall_count;

   hazard_scoreboard #(
      .NUM_REGS   (32),
      .ADDR_W     (5),
      .STALL_CNT_W(16)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .instr      (instr),
      .instr_valid(instr_valid),
      .rs1_used   (rs1_used),
      .rs2_used   (rs2_used),
      .rd_write   (rd_write),
      .issue_ready(issue_ready),
      .issue      (issue),
      .wb_en      (wb_en),
      .wb_rd      (wb_rd),
      .busy_vec   (busy_vec),
      .inflight   (inflight),
      .stall_count(stall_count),
      .wb_err     (wb_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst, vld, u1, u2, wr, wben;
      logic [4:0]  rs1, rs2, rd, wbrd;
      logic        exp_rdy;
      logic [31:0] exp_busy;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [31:0] busy;
      logic [5:0]  infl;
      logic [15:0] stall;
      logic        err;
   } sb_t;

   sb_t         sb_q[$];
   logic [31:0] m_busy;
   int          m_stall;
   logic        m_err;
   bit          m_known;
   int          n_checks;
   int          n_pass;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else n_pass++;
   endtask

   function automatic vec_t mk(input logic vld, input logic [4:0] rs1, input logic u1,
                               input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                               input logic wr, input logic wben, input logic [4:0] wbrd,
                               input logic exp_rdy, input logic [31:0] exp_busy,
                               input logic exp_err);
      vec_t v;
      v.rst = 1'b0; v.vld = vld; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.rd = rd; v.wr = wr; v.wben = wben; v.wbrd = wbrd;
      v.exp_rdy = exp_rdy; v.exp_busy = exp_busy; v.exp_err = exp_err;
      return v;
   endfunction

   function automatic vec_t rand_rst();
      vec_t v;
      v = mk(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
             5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 1'b1, '0, 1'b0);
      v.rst = 1'b1;
      return v;
   endfunction

   task automatic step(input vec_t v, input bit use_exp);
      bit          rdy, set, clr;
      logic [31:0] nb;
      sb_t         e, got;
      reset       = v.rst;
      instr_valid = v.vld;
      instr       = {7'h00, v.rs2, v.rs1, 3'h0, v.rd, 7'h33};
      rs1_used    = v.u1;
      rs2_used    = v.u2;
      rd_write    = v.wr;
      wb_en       = v.wben;
      wb_rd       = v.wbrd;
      #1;
      rdy = !((v.u1 && v.rs1 != 0 && m_busy[v.rs1]) || (v.u2 && v.rs2 != 0 && m_busy[v.rs2]) ||
              (v.wr && v.rd != 0 && m_busy[v.rd]));
      if (m_known) begin
         chk("issue_ready", {63'd0, issue_ready}, {63'd0, rdy});
         chk("issue", {63'd0, issue}, {63'd0, v.vld && rdy});
         if (use_exp) chk("tbl_ready", {63'd0, issue_ready}, {63'd0, v.exp_rdy});
      end
      if (v.rst) begin
         nb = '0; m_stall = 0; m_err = 1'b0;
      end else begin
         set = v.vld && rdy && v.wr && v.rd != 0;
         clr = v.wben && v.wbrd != 0 && !(set && v.wbrd == v.rd);
         nb = m_busy;
         m_err = clr && !m_busy[v.wbrd];
         if (set) nb[v.rd] = 1'b1;
         if (clr) nb[v.wbrd] = 1'b0;
         if (v.vld && !rdy && m_stall < 65535) m_stall++;
      end
      m_busy  = nb;
      m_known = 1'b1;
      e.busy  = nb;
      e.infl  = 6'($countones(nb));
      e.stall = 16'(m_stall);
      e.err   = m_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk("sb_empty", 64'd0, 64'd1);
      end else begin
         got = sb_q.pop_front();
         chk("busy_vec", {32'd0, busy_vec}, {32'd0, got.busy});
         chk("inflight", {58'd0, inflight}, {58'd0, got.infl});
         chk("stall_count", {48'd0, stall_count}, {48'd0, got.stall});
         chk("wb_err", {63'd0, wb_err}, {63'd0, got.err});
         if (use_exp) begin
            chk("tbl_busy", {32'd0, busy_vec}, {32'd0, v.exp_busy});
            chk("tbl_err", {63'd0, wb_err}, {63'd0, v.exp_err});
         end
      end
   endtask

   vec_t tbl[19];
   vec_t idle;

   initial begin
      n_checks = 0; n_pass = 0;
      m_busy = '0; m_stall = 0; m_err = 1'b0; m_known = 1'b0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

      // vld  rs1 u1  rs2 u2  rd wr  wben wbrd  rdy  busy-after    err
      tbl[0]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0,  1, 32'h0000_0020, 0);
      tbl[1]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0,  0, 32'h0000_0020, 0);
      tbl[2]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0,  0, 32'h0000_0020, 0);
      tbl[3]  = mk(1, 5, 1, 0, 0, 6, 1, 1, 5,  0, 32'h0000_0000, 0);
      tbl[4]  = mk(1, 5, 1, 0, 0, 6, 1, 0, 0,  1, 32'h0000_0040, 0);
      tbl[5]  = mk(0, 5, 1, 0, 0, 0, 0, 1, 6,  1, 32'h0000_0000, 0);
      tbl[6]  = mk(1, 0, 0, 0, 0, 0, 1, 0, 0,  1, 32'h0000_0000, 0);
      tbl[7]  = mk(1, 0, 1, 0, 1, 0, 0, 0, 0,  1, 32'h0000_0000, 0);
      tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0,  1, 32'h0000_0000, 0);
      tbl[9]  = mk(1, 0, 0, 0, 0, 7, 1, 1, 7,  1, 32'h0000_0080, 0);
      tbl[10] = mk(1, 0, 0, 0, 0, 3, 1, 1, 7,  1, 32'h0000_0008, 0);
      tbl[11] = mk(1, 0, 0, 0, 0, 3, 1, 1, 3,  0, 32'h0000_0000, 0);
      tbl[12] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  1, 32'h0000_0200, 0);
      tbl[13] = mk(1, 0, 0, 0, 0, 9, 1, 0, 0,  0, 32'h0000_0200, 0);
      tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 32'h0000_0200, 1);
      tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h0000_0200, 0);
      tbl[16] = mk(1, 0, 0, 9, 1, 0, 0, 0, 0,  0, 32'h0000_0200, 0);
      tbl[17] = mk(1, 0, 0, 9, 0, 0, 0, 0, 0,  1, 32'h0000_0200, 0);
      tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 1, 9,  1, 32'h0000_0000, 0);

      step(rand_rst(), 1'b0);
      step(rand_rst(), 1'b0);
      step(idle, 1'b1);

      for (int i = 0; i < 19; i++) step(tbl[i], 1'b1);

      // Fill every register with back-to-back issues.
      for (int r = 1; r < 32; r++) step(mk(1, 0, 0, 0, 0, 5'(r), 1, 0, 0, 1, 0, 0), 1'b0);
      chk("fill_inflight", {58'd0, inflight}, 64'd31);
      chk("fill_busy", {32'd0, busy_vec}, 64'hFFFF_FFFE);

      for (int i = 0; i < 65541; i++) step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1'b0);
      chk("stall_sat", {48'd0, stall_count}, 64'hFFFF);

      // Reset mid-operation with a write-back and issue presented.
      begin
         vec_t v;
         v = mk(1, 0, 0, 0, 0, 0, 1, 1, 4, 1, 0, 0);
         v.rst = 1'b1;
         step(v, 1'b1);
      end
      chk("rst_inflight", {58'd0, inflight}, 64'd0);
      chk("rst_stall", {48'd0, stall_count}, 64'd0);
      step(idle, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
